// File: rtl/nios_accelerometer_pkg.sv
// Shared register map and edge-type encodings for the accelerometer input capture block.
package nios_accelerometer_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RSVD = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/nios_accelerometer_edge_detect.sv
// Per-bit input conditioning and edge detection.
// NIOS_ACC_INPUT_SYNC_EN: when defined, in_port passes through a 2-flop synchroniser;
// otherwise in_port is treated as synchronous and sampled in a single register.
module nios_accelerometer_edge_detect
  import nios_accelerometer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int EDGE_TYPE  = EDGE_RISING
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] hits
);

  logic [DATA_WIDTH-1:0] cur;
  logic [DATA_WIDTH-1:0] prev;
  logic                  cur_valid;
  logic                  primed;
  logic [DATA_WIDTH-1:0] raw;

`ifdef NIOS_ACC_INPUT_SYNC_EN
  logic [DATA_WIDTH-1:0] sync1;
  logic [DATA_WIDTH-1:0] sync2;
  logic [1:0]            valid;

  // Two-stage synchroniser plus a fill tracker so prime waits for real samples
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      valid <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      valid <= {valid[0], 1'b1};
    end
  end

  assign cur       = sync2;
  assign cur_valid = valid[1];
  assign data      = sync2;
`else
  // Input already synchronous: compare live input against its one-cycle-old sample
  assign cur       = in_port;
  assign cur_valid = 1'b1;
  assign data      = prev;
`endif

  // Previous sample and prime flag; first valid sample only seeds prev
  always_ff @(posedge clk) begin
    if (reset) begin
      prev   <= '0;
      primed <= 1'b0;
    end else begin
      prev   <= cur;
      primed <= cur_valid;
    end
  end

  // Edge qualification by configured type, gated until primed
  always_comb begin
    raw = '0;
    if (EDGE_TYPE == EDGE_RISING)       raw = cur & ~prev;
    else if (EDGE_TYPE == EDGE_FALLING) raw = prev & ~cur;
    else                                raw = prev ^ cur;
    hits = primed ? raw : '0;
  end

endmodule

// File: rtl/nios_accelerometer_input_capture.sv
// Avalon-MM parallel input port with edge capture and maskable level interrupt.
// Optional build macro: NIOS_ACC_INPUT_SYNC_EN (2-flop input synchroniser).
module nios_accelerometer_input_capture
  import nios_accelerometer_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    EDGE_TYPE  = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_MASK = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] hits;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] edge_capture;
  logic [DATA_WIDTH-1:0] clear;
  logic [31:0]           rd_mux;
  logic                  rd_en;
  logic                  wr_en;
  logic                  unused_wdata;

  assign rd_en        = chipselect & read;
  assign wr_en        = chipselect & write;
  assign unused_wdata = ^writedata;

  nios_accelerometer_edge_detect #(
    .DATA_WIDTH (DATA_WIDTH),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_edge_detect (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .data    (data),
    .hits    (hits)
  );

  // Write-1-to-clear bits for the edge capture register
  always_comb begin
    clear = '0;
    if (wr_en && address == ADDR_EDGE) clear = writedata[DATA_WIDTH-1:0];
  end

  // Interrupt mask register
  always_ff @(posedge clk) begin
    if (reset)                               mask <= RESET_MASK;
    else if (wr_en && address == ADDR_MASK)  mask <= writedata[DATA_WIDTH-1:0];
  end

  // Edge capture: detection is OR-ed after the clear so a same-cycle set wins
  always_ff @(posedge clk) begin
    if (reset) edge_capture <= '0;
    else       edge_capture <= (edge_capture & ~clear) | hits;
  end

  // Registered level interrupt
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(edge_capture & mask);
  end

  // Read mux, zero-extended to the bus width
  always_comb begin
    rd_mux = '0;
    unique case (addr_e'(address))
      ADDR_DATA: rd_mux[DATA_WIDTH-1:0] = data;
      ADDR_RSVD: rd_mux = '0;
      ADDR_MASK: rd_mux[DATA_WIDTH-1:0] = mask;
      ADDR_EDGE: rd_mux[DATA_WIDTH-1:0] = edge_capture;
    endcase
  end

  // Registered read data, held between reads
  always_ff @(posedge clk) begin
    if (reset)      readdata <= '0;
    else if (rd_en) readdata <= rd_mux;
  end

endmodule

// File: tb/tb_nios_accelerometer_input_capture.sv
// Directed self-checking bench: three instances (rising, falling, any edge).
module tb_nios_accelerometer_input_capture;
  import nios_accelerometer_pkg::*;

`ifdef NIOS_ACC_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [2:0]  cs;
  logic [15:0] in0, in1, in2;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  nios_accelerometer_input_capture #(
    .DATA_WIDTH (16),
    .EDGE_TYPE  (0),
    .RESET_MASK (16'h0000)
  ) dut0 (
    .clk (clk), .reset (reset), .address (address), .chipselect (cs[0]),
    .read (read), .write (write), .writedata (writedata), .in_port (in0),
    .readdata (rd0), .irq (irq0)
  );

  nios_accelerometer_input_capture #(
    .DATA_WIDTH (16),
    .EDGE_TYPE  (1),
    .RESET_MASK (16'h0000)
  ) dut1 (
    .clk (clk), .reset (reset), .address (address), .chipselect (cs[1]),
    .read (read), .write (write), .writedata (writedata), .in_port (in1),
    .readdata (rd1), .irq (irq1)
  );

  nios_accelerometer_input_capture #(
    .DATA_WIDTH (16),
    .EDGE_TYPE  (2),
    .RESET_MASK (16'h00A5)
  ) dut2 (
    .clk (clk), .reset (reset), .address (address), .chipselect (cs[2]),
    .read (read), .write (write), .writedata (writedata), .in_port (in2),
    .readdata (rd2), .irq (irq2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] sel, input logic [1:0] a, input logic [31:0] d);
    cs = sel; address = a; writedata = d; write = 1'b1;
    tick;
    cs = '0; write = 1'b0; writedata = '0;
  endtask

  task automatic bus_read(input int idx, input logic [1:0] a, output logic [31:0] d);
    cs = '0; cs[idx] = 1'b1; address = a; read = 1'b1;
    tick;
    cs = '0; read = 1'b0;
    d = (idx == 0) ? rd0 : (idx == 1) ? rd1 : rd2;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    in0 = 16'hFFFF; in1 = 16'hFFFF; in2 = 16'hFFFF;
    reset = 1'b1;
    repeat (3) tick;
    total++; if (rd0 !== 32'h0) begin bad++; $display("FAIL reset_readdata: got %h want 00000000", rd0); end
    total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq0); end
    reset = 1'b0;
    repeat (LAT + 2) tick;
    total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL prime_irq0: got %b want 0", irq0); end
    total++; if (irq2 !== 1'b0) begin bad++; $display("FAIL prime_irq2: got %b want 0", irq2); end
    bus_read(0, ADDR_EDGE, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL prime_edge0: got %h want 00000000", d); end
    bus_read(2, ADDR_EDGE, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL prime_edge2: got %h want 00000000", d); end
    bus_read(0, ADDR_DATA, d);
    total++; if (d !== 32'h0000FFFF) begin bad++; $display("FAIL reset_data: got %h want 0000ffff", d); end
    bus_read(0, ADDR_MASK, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_mask0: got %h want 00000000", d); end
    bus_read(2, ADDR_MASK, d);
    total++; if (d !== 32'h000000A5) begin bad++; $display("FAIL reset_mask2: got %h want 000000a5", d); end
  endtask

  task automatic test_rising;
    logic exp;
    in0 = 16'h0000;
    repeat (LAT + 2) tick;
    bus_write(3'b001, ADDR_MASK, 32'h1);
    cs = 3'b001; address = ADDR_EDGE; read = 1'b1;
    in0 = 16'h0001;
    for (int n = 1; n <= LAT + 1; n++) begin
      tick;
      exp = (n == LAT + 1);
      total++; if (rd0 !== {31'b0, exp}) begin bad++; $display("FAIL rise_edge_c%0d: got %h want %h", n, rd0, {31'b0, exp}); end
      total++; if (irq0 !== exp) begin bad++; $display("FAIL rise_irq_c%0d: got %b want %b", n, irq0, exp); end
    end
    cs = '0; read = 1'b0;
  endtask

  task automatic test_clear;
    logic [31:0] d;
    bus_write(3'b001, ADDR_EDGE, 32'h1);
    total++; if (irq0 !== 1'b1) begin bad++; $display("FAIL clear_irq_hold: got %b want 1", irq0); end
    tick;
    total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL clear_irq_drop: got %b want 0", irq0); end
    bus_read(0, ADDR_EDGE, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL clear_edge: got %h want 00000000", d); end
    in0 = 16'h0000;
    repeat (LAT + 2) tick;
    in0 = 16'h0001;
    repeat (LAT - 1) tick;
    bus_write(3'b001, ADDR_EDGE, 32'h1);
    bus_read(0, ADDR_EDGE, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL set_priority_edge: got %h want 00000001", d); end
    total++; if (irq0 !== 1'b1) begin bad++; $display("FAIL set_priority_irq: got %b want 1", irq0); end
    bus_write(3'b001, ADDR_EDGE, 32'h1);
    tick;
  endtask

  task automatic test_falling;
    logic [31:0] d;
    in1 = 16'hFFF7;
    repeat (LAT + 1) tick;
    bus_read(1, ADDR_EDGE, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL fall_edge: got %h want 00000008", d); end
    in1 = 16'hFFFF;
    repeat (LAT + 1) tick;
    bus_read(1, ADDR_EDGE, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL fall_ignore_rise: got %h want 00000008", d); end
    total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL fall_irq_masked: got %b want 0", irq1); end
  endtask

  task automatic test_any;
    logic [31:0] d;
    bus_write(3'b100, ADDR_MASK, 32'h0);
    in2 = 16'h0000;
    repeat (LAT + 2) tick;
    bus_write(3'b100, ADDR_EDGE, 32'hFFFFFFFF);
    bus_read(2, ADDR_EDGE, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL any_cleared: got %h want 00000000", d); end
    in2 = 16'h0020;
    tick;
    in2 = 16'h0000;
    repeat (LAT + 2) tick;
    bus_read(2, ADDR_EDGE, d);
    total++; if (d !== 32'h20) begin bad++; $display("FAIL any_edge: got %h want 00000020", d); end
    total++; if (irq2 !== 1'b0) begin bad++; $display("FAIL any_irq_masked: got %b want 0", irq2); end
    bus_write(3'b100, ADDR_MASK, 32'hFFFF0020);
    total++; if (irq2 !== 1'b0) begin bad++; $display("FAIL any_irq_lag: got %b want 0", irq2); end
    tick;
    total++; if (irq2 !== 1'b1) begin bad++; $display("FAIL any_irq_set: got %b want 1", irq2); end
    bus_read(2, ADDR_MASK, d);
    total++; if (d !== 32'h20) begin bad++; $display("FAIL any_mask_trunc: got %h want 00000020", d); end
  endtask

  task automatic test_reserved;
    logic [31:0] d;
    bus_read(0, ADDR_RSVD, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rsvd_read: got %h want 00000000", d); end
    bus_write(3'b001, ADDR_DATA, 32'hFFFFFFFF);
    bus_write(3'b001, ADDR_RSVD, 32'hFFFFFFFF);
    bus_read(0, ADDR_EDGE, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rsvd_edge_kept: got %h want 00000000", d); end
    bus_read(0, ADDR_DATA, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL rsvd_data: got %h want 00000001", d); end
    bus_read(0, ADDR_MASK, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL rsvd_mask_kept: got %h want 00000001", d); end
    cs = '0; address = ADDR_EDGE; read = 1'b1;
    repeat (2) tick;
    read = 1'b0;
    tick;
    total++; if (rd0 !== 32'h1) begin bad++; $display("FAIL read_no_cs_hold: got %h want 00000001", rd0); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    bus_read(0, ADDR_MASK, d);
    in0 = 16'h0000;
    repeat (LAT + 2) tick;
    in0 = 16'h0001;
    tick;
    reset = 1'b1;
    cs = 3'b001; address = ADDR_MASK; writedata = 32'h0000FFFF; write = 1'b1;
    tick;
    cs = '0; write = 1'b0; writedata = '0;
    tick;
    total++; if (rd0 !== 32'h0) begin bad++; $display("FAIL mid_reset_readdata: got %h want 00000000", rd0); end
    total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL mid_reset_irq: got %b want 0", irq0); end
    reset = 1'b0;
    repeat (LAT + 2) tick;
    bus_read(0, ADDR_EDGE, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_reset_edge: got %h want 00000000", d); end
    total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL mid_reset_irq_after: got %b want 0", irq0); end
    bus_read(0, ADDR_MASK, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_reset_mask0: got %h want 00000000", d); end
    bus_read(2, ADDR_MASK, d);
    total++; if (d !== 32'h000000A5) begin bad++; $display("FAIL mid_reset_mask2: got %h want 000000a5", d); end
  endtask

  initial begin
    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0; cs = '0;
    in0 = '0; in1 = '0; in2 = '0;
    test_reset;
    test_rising;
    test_clear;
    test_falling;
    test_any;
    test_reserved;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
